mm_codebreaker: RTL and testbench

Automatic Mastermind codebreaker: the guessing side of the scoring protocol. It issues 4-digit, 2-bit-per-digit guesses, accepts the scorer's `numCorrectAll` / `numCorrWrongPlace` feedback, keeps a history of guesses and feedback, and scans the 256-code space for the next code consistent with every stored result. It sits across from the scorer and drives its guess inputs in place of the switch-entry path.

---
 rtl/mm_pkg.sv | 29 ++
 rtl/mm_score.sv | 54 +++++
 rtl/mm_codebreaker.sv | 218 +++++++++++++++++++++
 tb/tb_mm_codebreaker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg
// Shared types and constants for the Mastermind codebreaker.
//   code_t     : packed 4 x 2-bit code; digit 3 sits in bits [7:6] and is the
//                first digit shown to the scorer, digit 0 sits in bits [1:0].
//   score_t    : exact / partial feedback pair, 3 bits each.
//   state_t    : codebreaker FSM states.
//   NUM_DIGITS : positions per code.
//   NUM_COLORS : colours per position.
package mm_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_COLORS = 4;

  typedef logic [NUM_DIGITS-1:0][1:0] code_t;

  typedef struct packed {
    logic [2:0] exact;
    logic [2:0] part;
  } score_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/mm_score.sv
// mm_score
// Combinational Mastermind scorer. Scores code_a against code_b.
// Ports:
//   code_a : input  code_t  - first code (candidate)
//   code_b : input  code_t  - second code (stored guess)
//   score  : output score_t - exact = equal positions,
//                             part  = sum over colours of the smaller
//                                     occurrence count, minus exact
module mm_score
  import mm_pkg::*;
(
  input  code_t  code_a,
  input  code_t  code_b,
  output score_t score
);

  logic [2:0] exact_cnt;
  logic [2:0] total_cnt;
  logic [2:0] a_cnt;
  logic [2:0] b_cnt;

  // Count exact positional matches, then for every colour count how often it
  // appears in each code and add the smaller of the two. The colour total
  // already includes the exact hits, so they are removed to leave the
  // "right colour, wrong place" part. total >= exact always holds, so the
  // subtraction cannot underflow.
  always_comb begin
    exact_cnt = '0;
    total_cnt = '0;
    a_cnt     = '0;
    b_cnt     = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (code_a[d] == code_b[d]) begin
        exact_cnt = exact_cnt + 3'd1;
      end
    end
    for (int c = 0; c < NUM_COLORS; c++) begin
      a_cnt = '0;
      b_cnt = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (code_a[d] == 2'(c)) begin
          a_cnt = a_cnt + 3'd1;
        end
        if (code_b[d] == 2'(c)) begin
          b_cnt = b_cnt + 3'd1;
        end
      end
      total_cnt = total_cnt + ((a_cnt < b_cnt) ? a_cnt : b_cnt);
    end
    score.exact = exact_cnt;
    score.part  = total_cnt - exact_cnt;
  end

endmodule

// File: rtl/mm_codebreaker.sv
// mm_codebreaker
// Automatic Mastermind codebreaker. Issues guesses to a scorer, records the
// feedback, and scans the 256-code space in ascending order for the next code
// consistent with every recorded result.
// Parameters:
//   MAX_GUESSES : history depth and number of non-winning guesses before fail
// Ports:
//   clk                    : input  - clock
//   Reset                  : input  - synchronous active-high reset
//   start                  : input  - begin a game (IDLE/DONE/FAIL only)
//   feedback_valid         : input  - scorer result valid (PRESENT only)
//   numCorrectAll     [2:0]: input  - exact-position matches
//   numCorrWrongPlace [2:0]: input  - right colour, wrong place
//   guessed*Digit     [1:0]: output - current guess, first digit = bits [7:6]
//   guess_valid            : output - guess is being presented
//   busy                   : output - SCAN or PRESENT
//   solved                 : output - DONE
//   fail                   : output - FAIL
//   guess_count            : output - non-winning guesses so far; present only
//                                     when MM_GUESS_COUNT_EN is defined
module mm_codebreaker
  import mm_pkg::*;
#(
  parameter  int MAX_GUESSES = 10,
  localparam int GCW         = $clog2(MAX_GUESSES + 1)
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           start,
  input  logic           feedback_valid,
  input  logic [2:0]     numCorrectAll,
  input  logic [2:0]     numCorrWrongPlace,
  output logic [1:0]     guessedFirstDigit,
  output logic [1:0]     guessedSecondDigit,
  output logic [1:0]     guessedThirdDigit,
  output logic [1:0]     guessedFourthDigit,
  output logic           guess_valid,
  output logic           busy,
  output logic           solved,
  output logic           fail
`ifdef MM_GUESS_COUNT_EN
  ,
  output logic [GCW-1:0] guess_count
`endif
);

  state_t                 state;
  state_t                 state_next;

  logic [7:0]             cand;
  logic [GCW-1:0]         gcnt;
  logic [GCW-1:0]         gcnt_plus;
  code_t                  guess;

  code_t                  hist_code  [MAX_GUESSES];
  logic [2:0]             hist_exact [MAX_GUESSES];
  logic [2:0]             hist_part  [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] hist_valid;

  score_t                 hist_score [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] entry_ok;
  logic                   consistent;

  logic                   load_guess;
  logic                   cand_clear;
  logic                   cand_inc;
  logic                   cand_resume;
  logic                   hist_clear;
  logic                   hist_write;

  assign gcnt_plus = gcnt + GCW'(1);

  // One scorer per history slot so a candidate is checked against the whole
  // history in a single cycle. Empty slots never veto a candidate.
  for (genvar i = 0; i < MAX_GUESSES; i++) begin : g_hist
    mm_score u_score (
      .code_a (code_t'(cand)),
      .code_b (hist_code[i]),
      .score  (hist_score[i])
    );
    assign entry_ok[i] = !hist_valid[i] ||
                         ((hist_score[i].exact == hist_exact[i]) &&
                          (hist_score[i].part  == hist_part[i]));
  end

  assign consistent = &entry_ok;

  // State register. Reset wins over everything else in the same cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the datapath strobes and status outputs.
  // SCAN never wraps: an inconsistent 8'hFF means no code fits the history.
  // After a non-winning guess the scan resumes just past that guess, since
  // every lower code was already rejected by part of the same history.
  always_comb begin
    state_next  = state;
    load_guess  = 1'b0;
    cand_clear  = 1'b0;
    cand_inc    = 1'b0;
    cand_resume = 1'b0;
    hist_clear  = 1'b0;
    hist_write  = 1'b0;
    guess_valid = 1'b0;
    busy        = 1'b0;
    solved      = 1'b0;
    fail        = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        solved = (state == ST_DONE);
        fail   = (state == ST_FAIL);
        if (start) begin
          state_next = ST_SCAN;
          cand_clear = 1'b1;
          hist_clear = 1'b1;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (consistent) begin
          load_guess = 1'b1;
          state_next = ST_PRESENT;
        end else if (cand == 8'hFF) begin
          state_next = ST_FAIL;
        end else begin
          cand_inc = 1'b1;
        end
      end
      ST_PRESENT: begin
        busy        = 1'b1;
        guess_valid = 1'b1;
        if (feedback_valid) begin
          if (numCorrectAll == 3'd4) begin
            state_next = ST_DONE;
          end else begin
            hist_write = 1'b1;
            if (gcnt_plus == GCW'(MAX_GUESSES)) begin
              state_next = ST_FAIL;
            end else if (guess == code_t'(8'hFF)) begin
              state_next = ST_FAIL;
            end else begin
              cand_resume = 1'b1;
              state_next  = ST_SCAN;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Candidate counter, guess register, guess count and history valid bits.
  // The guess register is never touched outside SCAN, so DONE and FAIL keep
  // showing the last guess.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cand       <= '0;
      gcnt       <= '0;
      guess      <= '0;
      hist_valid <= '0;
    end else begin
      if (cand_clear) begin
        cand <= '0;
      end else if (cand_inc) begin
        cand <= cand + 8'd1;
      end else if (cand_resume) begin
        cand <= guess + 8'd1;
      end

      if (load_guess) begin
        guess <= code_t'(cand);
      end

      if (hist_clear) begin
        gcnt       <= '0;
        hist_valid <= '0;
      end else if (hist_write) begin
        gcnt <= gcnt_plus;
        for (int i = 0; i < MAX_GUESSES; i++) begin
          if (gcnt == GCW'(i)) begin
            hist_valid[i] <= 1'b1;
          end
        end
      end
    end
  end

  // History payload. It needs no reset because a slot is only looked at once
  // its valid bit has been set by a write.
  always_ff @(posedge clk) begin
    if (hist_write) begin
      for (int i = 0; i < MAX_GUESSES; i++) begin
        if (gcnt == GCW'(i)) begin
          hist_code[i]  <= guess;
          hist_exact[i] <= numCorrectAll;
          hist_part[i]  <= numCorrWrongPlace;
        end
      end
    end
  end

  assign guessedFirstDigit  = guess[3];
  assign guessedSecondDigit = guess[2];
  assign guessedThirdDigit  = guess[1];
  assign guessedFourthDigit = guess[0];

`ifdef MM_GUESS_COUNT_EN
  assign guess_count = gcnt;
`endif

endmodule

// File: tb/tb_mm_codebreaker.sv
// tb_mm_codebreaker
// Self-checking bench for mm_codebreaker. A behavioural model keeps the game
// history as queues, scores codes by pairing pegs, and predicts the next guess
// as the lowest code above the last guess that fits every recorded result.
module tb_mm_codebreaker;

  localparam int MAXG = 10;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       feedback_valid;
  logic [2:0] numCorrectAll;
  logic [2:0] numCorrWrongPlace;
  logic [1:0] guessedFirstDigit;
  logic [1:0] guessedSecondDigit;
  logic [1:0] guessedThirdDigit;
  logic [1:0] guessedFourthDigit;
  logic       guess_valid;
  logic       busy;
  logic       solved;
  logic       fail;
`ifdef MM_GUESS_COUNT_EN
  logic [$clog2(MAXG+1)-1:0] guess_count;
`endif

  int checkCount = 0;
  int errorCount = 0;

  bit [7:0] mCode[$];
  int       mEx[$];
  int       mPt[$];
  int       mGuess;
  int       mCount;

  always #5 clk = ~clk;

  mm_codebreaker #(.MAX_GUESSES(MAXG)) dut (
    .clk                (clk),
    .Reset              (Reset),
    .start              (start),
    .feedback_valid     (feedback_valid),
    .numCorrectAll      (numCorrectAll),
    .numCorrWrongPlace  (numCorrWrongPlace),
    .guessedFirstDigit  (guessedFirstDigit),
    .guessedSecondDigit (guessedSecondDigit),
    .guessedThirdDigit  (guessedThirdDigit),
    .guessedFourthDigit (guessedFourthDigit),
    .guess_valid        (guess_valid),
    .busy               (busy),
    .solved             (solved),
    .fail               (fail)
`ifdef MM_GUESS_COUNT_EN
    ,
    .guess_count        (guess_count)
`endif
  );

  // Current guess as shown on the digit outputs.
  function automatic int curGuess();
    return int'({guessedFirstDigit, guessedSecondDigit,
                 guessedThirdDigit, guessedFourthDigit});
  endfunction

  // Reference scoring: pair exact hits first, then greedily pair each
  // remaining peg of a with any unused equal peg of b.
  function automatic void tbScore(input bit [7:0] a, input bit [7:0] b,
                                  output int ex, output int pt);
    int da[4];
    int db[4];
    bit ua[4];
    bit ub[4];
    ex = 0;
    pt = 0;
    for (int i = 0; i < 4; i++) begin
      da[i] = int'((a >> (6 - 2 * i)) & 8'h3);
      db[i] = int'((b >> (6 - 2 * i)) & 8'h3);
      ua[i] = 1'b0;
      ub[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (da[i] == db[i]) begin
        ex++;
        ua[i] = 1'b1;
        ub[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!ua[i] && !ub[j] && da[i] == db[j]) begin
          pt++;
          ua[i] = 1'b1;
          ub[j] = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit modelConsistent(input int c);
    int ex;
    int pt;
    foreach (mCode[k]) begin
      tbScore(8'(c), mCode[k], ex, pt);
      if (ex != mEx[k] || pt != mPt[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Drive one cycle worth of inputs, then release the pulses #1 after the edge.
  task automatic applyStimulus(input logic s, input logic fv,
                               input logic [2:0] ca, input logic [2:0] cw);
    start             = s;
    feedback_valid    = fv;
    numCorrectAll     = ca;
    numCorrWrongPlace = cw;
    @(posedge clk);
    #1;
    start          = 1'b0;
    feedback_valid = 1'b0;
  endtask

  task automatic stepCycles(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_digits"}, curGuess(), 0);
    checkOutput({tag, "_guess_valid"}, guess_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_solved"}, solved, 0);
    checkOutput({tag, "_fail"}, fail, 0);
`ifdef MM_GUESS_COUNT_EN
    checkOutput({tag, "_guess_count"}, int'(guess_count), 0);
`endif
  endtask

  // Count edges until a guess, DONE or FAIL shows up, with a bounded wait.
  task automatic waitEvent(output int n);
    n = 0;
    while (!(guess_valid || solved || fail) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) checkOutput("wait_timeout", n, -1);
  endtask

  task automatic beginGame();
    int n;
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0);
    mCode.delete();
    mEx.delete();
    mPt.delete();
    mGuess = 0;
    mCount = 0;
    waitEvent(n);
    checkOutput("start_latency", n, 1);
    checkOutput("first_guess", curGuess(), 0);
    checkOutput("first_guess_valid", guess_valid, 1);
    checkOutput("first_busy", busy, 1);
`ifdef MM_GUESS_COUNT_EN
    checkOutput("first_guess_count", int'(guess_count), 0);
`endif
  endtask

  // Hold the guess for a while, answer it, and check the outcome.
  // result: 0 = new guess, 1 = solved, 2 = failed.
  task automatic answerAndCheck(input int ex, input int pt, input int hold,
                                output int result, output int n);
    int expN;
    int expCode;
    bit expFail;
    if (hold > 0) stepCycles(hold);
    checkOutput("hold_valid", guess_valid, 1);
    checkOutput("hold_guess", curGuess(), mGuess);
    applyStimulus(1'b0, 1'b1, 3'(ex), 3'(pt));
    if (ex == 4) begin
      n = 0;
      result = 1;
      checkOutput("done_solved", solved, 1);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_guess_valid", guess_valid, 0);
      checkOutput("done_digits", curGuess(), mGuess);
`ifdef MM_GUESS_COUNT_EN
      checkOutput("done_guess_count", int'(guess_count), mCount);
`endif
      return;
    end
    mCode.push_back(8'(mGuess));
    mEx.push_back(ex);
    mPt.push_back(pt);
    mCount++;
    expFail = 1'b0;
    expCode = -1;
    expN    = 0;
    if (mCount == MAXG || mGuess == 255) begin
      expFail = 1'b1;
    end else begin
      for (int c = mGuess + 1; c < 256; c++) begin
        if (modelConsistent(c)) begin
          expCode = c;
          break;
        end
      end
      if (expCode < 0) begin
        expFail = 1'b1;
        expN    = 255 - mGuess;
      end else begin
        expN = expCode - mGuess;
      end
    end
    waitEvent(n);
    checkOutput("latency", n, expN);
    if (expFail) begin
      result = 2;
      checkOutput("fail_flag", fail, 1);
      checkOutput("fail_busy", busy, 0);
      checkOutput("fail_solved", solved, 0);
      checkOutput("fail_digits", curGuess(), mGuess);
    end else begin
      result = 0;
      checkOutput("next_valid", guess_valid, 1);
      checkOutput("next_busy", busy, 1);
      checkOutput("next_guess", curGuess(), expCode);
      checkOutput("next_consistent", int'(modelConsistent(curGuess())), 1);
      mGuess = expCode;
    end
  endtask

  initial begin
    int r;
    int n;
    int secret;
    int offset;
    int ex;
    int pt;
    int turns;
    int seq[4];

    Reset             = 1'b1;
    start             = 1'b0;
    feedback_valid    = 1'b0;
    numCorrectAll     = 3'd0;
    numCorrWrongPlace = 3'd0;
    seq[0] = 8'h00;
    seq[1] = 8'h55;
    seq[2] = 8'hAA;
    seq[3] = 8'hFF;

    $display("[TB] reset and idle");
    stepCycles(2);
    Reset = 1'b0;
    checkIdle("reset");
    stepCycles(5);
    checkIdle("idle");

    $display("[TB] immediate solve");
    beginGame();
    answerAndCheck(4, 0, 0, r, n);
    checkOutput("solve0_result", r, 1);

    $display("[TB] all-zero feedback sequence");
    beginGame();
    for (int i = 1; i < 4; i++) begin
      answerAndCheck(0, 0, i - 1, r, n);
      checkOutput("seq_result", r, 0);
      checkOutput("seq_guess", curGuess(), seq[i]);
      checkOutput("seq_latency", n, 85);
    end
    answerAndCheck(0, 0, 0, r, n);
    checkOutput("seq_end_result", r, 2);
    checkOutput("seq_end_latency", n, 0);
    checkOutput("seq_end_fail", fail, 1);
    checkOutput("seq_end_busy", busy, 0);

    $display("[TB] stray pulses and mid-scan reset");
    beginGame();
    applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
    stepCycles(9);
    applyStimulus(1'b1, 1'b1, 3'd4, 3'd0);
    stepCycles(74);
    checkOutput("stray_still_scanning", guess_valid, 0);
    checkOutput("stray_busy", busy, 1);
    stepCycles(1);
    checkOutput("stray_guess_valid", guess_valid, 1);
    checkOutput("stray_guess", curGuess(), 8'h55);
    applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
    stepCycles(5);
    checkOutput("midscan_busy", busy, 1);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd4, 3'd0);
    Reset = 1'b0;
    checkIdle("midscan_reset");
    applyStimulus(1'b0, 1'b1, 3'd4, 3'd0);
    stepCycles(3);
    checkIdle("idle_feedback");
    beginGame();
    answerAndCheck(4, 0, 1, r, n);

    $display("[TB] closed loop over all secrets");
    offset = int'($urandom_range(0, 255));
    for (int s = 0; s < 256; s++) begin
      secret = (s + offset) % 256;
      beginGame();
      r = 0;
      turns = 0;
      while (r == 0 && turns <= MAXG) begin
        tbScore(8'(mGuess), 8'(secret), ex, pt);
        answerAndCheck(ex, pt, int'($urandom_range(0, 2)), r, n);
        turns++;
      end
      checkOutput($sformatf("solve_secret_%0d", secret), r, 1);
    end

    $display("[TB] random feedback games");
    for (int g = 0; g < 20; g++) begin
      beginGame();
      r = 0;
      turns = 0;
      while (r == 0 && turns <= MAXG) begin
        if ($urandom_range(0, 9) == 0) begin
          ex = 4;
          pt = 0;
        end else begin
          ex = int'($urandom_range(0, 3));
          pt = int'($urandom_range(0, 4));
        end
        answerAndCheck(ex, pt, int'($urandom_range(0, 3)), r, n);
        turns++;
      end
      checkOutput("random_game_ended", int'(r != 0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
